// File: rtl/tlul_pkg.sv
// Shared TL-UL 64-bit channel types, opcodes and error-responder state encoding.
package tlul_pkg;

    localparam int unsigned TL_DW64 = 64;
    localparam int unsigned TL_AW   = 32;
    localparam int unsigned TL_DBW  = TL_DW64 / 8;
    localparam int unsigned TL_SZW  = 2;
    localparam int unsigned TL_AIW  = 8;
    localparam int unsigned TL_DIW  = 1;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef enum logic {
        ErrIdle,
        ErrResp
    } err_resp_state_e;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [7:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [7:0] data_intg;
    } tl_d_user_t;

    localparam tl_d_user_t TL_D_USER_DEFAULT = '{rsp_intg: '0, data_intg: '0};

    typedef struct packed {
        logic               a_valid;
        tl_a_op_e           a_opcode;
        logic [2:0]         a_param;
        logic [TL_SZW-1:0]  a_size;
        logic [TL_AIW-1:0]  a_source;
        logic [TL_AW-1:0]   a_address;
        logic [TL_DBW-1:0]  a_mask;
        logic [TL_DW64-1:0] a_data;
        tl_a_user_t         a_user;
        logic               d_ready;
    } tl_h2d_t64;

    typedef struct packed {
        logic               d_valid;
        tl_d_op_e           d_opcode;
        logic [2:0]         d_param;
        logic [TL_SZW-1:0]  d_size;
        logic [TL_AIW-1:0]  d_source;
        logic [TL_DIW-1:0]  d_sink;
        logic [TL_DW64-1:0] d_data;
        tl_d_user_t         d_user;
        logic               d_error;
        logic               a_ready;
    } tl_d2h_t64;

endpackage

// File: rtl/tlul_err_resp64_cnt.sv
// Saturating event counter for the 64-bit TL-UL error responder.
module tlul_err_resp64_cnt #(
    parameter int unsigned CntW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    output logic [CntW-1:0] cnt
);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {CntW{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tlul_err_resp64.sv
// TL-UL 64-bit error responder: answers one steered A beat with a d_error=1 response.
// Optional saturating error counter on err_cnt_o when TLUL_ERR_RESP64_CNT_EN is defined.
module tlul_err_resp64
    import tlul_pkg::*;
#(
    parameter int unsigned CntW = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  tl_h2d_t64       tl_h2d_i,
    output tl_d2h_t64       tl_d2h_o
`ifdef TLUL_ERR_RESP64_CNT_EN
    ,
    output logic [CntW-1:0] err_cnt_o
`endif
);

    err_resp_state_e   state_q;
    err_resp_state_e   state_d;
    logic              is_get_q;
    logic [TL_SZW-1:0] size_q;
    logic [TL_AIW-1:0] source_q;
    logic              a_hs;

    assign a_hs = tl_h2d_i.a_valid && (state_q == ErrIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ErrIdle: if (tl_h2d_i.a_valid) state_d = ErrResp;
            ErrResp: if (tl_h2d_i.d_ready) state_d = ErrIdle;
            default: state_d = ErrIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ErrIdle;
            is_get_q <= 1'b0;
            size_q   <= '0;
            source_q <= '0;
        end else begin
            state_q <= state_d;
            if (a_hs) begin
                is_get_q <= (tl_h2d_i.a_opcode == Get);
                size_q   <= tl_h2d_i.a_size;
                source_q <= tl_h2d_i.a_source;
            end
        end
    end

    // Response fields decode only from registered state, never from A inputs.
    always_comb begin
        tl_d2h_o          = '0;
        tl_d2h_o.d_valid  = (state_q == ErrResp);
        tl_d2h_o.a_ready  = (state_q == ErrIdle);
        tl_d2h_o.d_opcode = is_get_q ? AccessAckData : AccessAck;
        tl_d2h_o.d_param  = '0;
        tl_d2h_o.d_size   = size_q;
        tl_d2h_o.d_source = source_q;
        tl_d2h_o.d_sink   = '0;
        tl_d2h_o.d_data   = is_get_q ? {TL_DW64{1'b1}} : '0;
        tl_d2h_o.d_user   = TL_D_USER_DEFAULT;
        tl_d2h_o.d_error  = 1'b1;
    end

    logic unused_a;
    assign unused_a = ^{tl_h2d_i.a_param, tl_h2d_i.a_address,
                        tl_h2d_i.a_mask, tl_h2d_i.a_data,
                        tl_h2d_i.a_user};

`ifdef TLUL_ERR_RESP64_CNT_EN
    tlul_err_resp64_cnt #(
        .CntW (CntW)
    ) u_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (a_hs),
        .cnt   (err_cnt_o)
    );
`else
    logic [CntW-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_tlul_err_resp64.sv
// Directed bench for tlul_err_resp64; counter steps run when TLUL_ERR_RESP64_CNT_EN is defined.
module tb_tlul_err_resp64;
    import tlul_pkg::*;

    logic      clk;
    logic      rst_ni;
    tl_h2d_t64 h2d;
    tl_d2h_t64 d2h;
    int        n_vec;
    int        n_err;
`ifdef TLUL_ERR_RESP64_CNT_EN
    logic [1:0] err_cnt;
`endif

    tlul_err_resp64 #(
        .CntW (2)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .tl_h2d_i (h2d),
        .tl_d2h_o (d2h)
`ifdef TLUL_ERR_RESP64_CNT_EN
        ,
        .err_cnt_o (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        h2d = '0;
        rst_ni = 1'b0;
        #2;
        chk("rst_d_valid", 64'(d2h.d_valid), 64'd0);
        chk("rst_a_ready", 64'(d2h.a_ready), 64'd1);
        chk("rst_d_source", 64'(d2h.d_source), 64'd0);
`ifdef TLUL_ERR_RESP64_CNT_EN
        chk("rst_cnt", 64'(err_cnt), 64'd0);
`endif
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // 1: Get, source 5, size 3, d_ready high
        h2d.a_valid  = 1'b1;
        h2d.a_opcode = Get;
        h2d.a_source = 8'd5;
        h2d.a_size   = 2'd3;
        h2d.d_ready  = 1'b1;
        #1;
        chk("t1_pre_d_valid", 64'(d2h.d_valid), 64'd0);
        tick();
        h2d.a_valid = 1'b0;
        chk("t1_d_valid", 64'(d2h.d_valid), 64'd1);
        chk("t1_opcode", 64'(d2h.d_opcode), 64'(AccessAckData));
        chk("t1_error", 64'(d2h.d_error), 64'd1);
        chk("t1_data", d2h.d_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_source", 64'(d2h.d_source), 64'd5);
        chk("t1_size", 64'(d2h.d_size), 64'd3);
        chk("t1_param", 64'(d2h.d_param), 64'd0);
        chk("t1_sink", 64'(d2h.d_sink), 64'd0);
        chk("t1_a_ready", 64'(d2h.a_ready), 64'd0);
        tick();
        chk("t1_idle_d_valid", 64'(d2h.d_valid), 64'd0);
        chk("t1_idle_a_ready", 64'(d2h.a_ready), 64'd1);

        // 2: PutFullData, source 2, d_ready low 4 cycles
        h2d.a_valid  = 1'b1;
        h2d.a_opcode = PutFullData;
        h2d.a_source = 8'd2;
        h2d.a_size   = 2'd2;
        h2d.d_ready  = 1'b0;
        tick();
        h2d.a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_d_valid", 64'(d2h.d_valid), 64'd1);
            chk("t2_opcode", 64'(d2h.d_opcode), 64'(AccessAck));
            chk("t2_error", 64'(d2h.d_error), 64'd1);
            chk("t2_data", d2h.d_data, 64'd0);
            chk("t2_source", 64'(d2h.d_source), 64'd2);
            chk("t2_size", 64'(d2h.d_size), 64'd2);
            chk("t2_a_ready", 64'(d2h.a_ready), 64'd0);
            if (i < 3) tick();
        end
        h2d.d_ready = 1'b1;
        tick();
        chk("t2_done_d_valid", 64'(d2h.d_valid), 64'd0);
        chk("t2_done_a_ready", 64'(d2h.a_ready), 64'd1);

        // 3: back-to-back Get then PutPartialData
        h2d.a_valid  = 1'b1;
        h2d.a_opcode = Get;
        h2d.a_source = 8'd9;
        h2d.a_size   = 2'd1;
        tick();
        h2d.a_opcode = PutPartialData;
        h2d.a_source = 8'd10;
        h2d.a_size   = 2'd0;
        chk("t3a_d_valid", 64'(d2h.d_valid), 64'd1);
        chk("t3a_opcode", 64'(d2h.d_opcode), 64'(AccessAckData));
        chk("t3a_source", 64'(d2h.d_source), 64'd9);
        chk("t3a_a_ready", 64'(d2h.a_ready), 64'd0);
        tick();
        chk("t3_gap_d_valid", 64'(d2h.d_valid), 64'd0);
        chk("t3_gap_a_ready", 64'(d2h.a_ready), 64'd1);
        tick();
        h2d.a_valid = 1'b0;
        chk("t3b_d_valid", 64'(d2h.d_valid), 64'd1);
        chk("t3b_opcode", 64'(d2h.d_opcode), 64'(AccessAck));
        chk("t3b_data", d2h.d_data, 64'd0);
        chk("t3b_source", 64'(d2h.d_source), 64'd10);
        chk("t3b_size", 64'(d2h.d_size), 64'd0);
        tick();
        chk("t3_end_d_valid", 64'(d2h.d_valid), 64'd0);

        // 4: illegal opcode answered as AccessAck
        h2d.a_valid  = 1'b1;
        h2d.a_opcode = tl_a_op_e'(3'h7);
        h2d.a_source = 8'd3;
        h2d.a_size   = 2'd0;
        h2d.d_ready  = 1'b0;
        tick();
        h2d.a_valid = 1'b0;
        chk("t4_d_valid", 64'(d2h.d_valid), 64'd1);
        chk("t4_opcode", 64'(d2h.d_opcode), 64'(AccessAck));
        chk("t4_error", 64'(d2h.d_error), 64'd1);
        chk("t4_data", d2h.d_data, 64'd0);
        chk("t4_source", 64'(d2h.d_source), 64'd3);
        tick();
        chk("t4_hold_d_valid", 64'(d2h.d_valid), 64'd1);

        // 5: async reset while in RESP
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t5_d_valid", 64'(d2h.d_valid), 64'd0);
        chk("t5_a_ready", 64'(d2h.a_ready), 64'd1);
        chk("t5_source", 64'(d2h.d_source), 64'd0);
        tick();
        rst_ni = 1'b1;
        h2d.d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_post_d_valid", 64'(d2h.d_valid), 64'd0);
            chk("t5_post_a_ready", 64'(d2h.a_ready), 64'd1);
        end

`ifdef TLUL_ERR_RESP64_CNT_EN
        // 6: saturating counter, CntW=2
        chk("t6_cnt_start", 64'(err_cnt), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            h2d.a_valid  = 1'b1;
            h2d.a_opcode = Get;
            h2d.a_source = 8'(k);
            tick();
            h2d.a_valid = 1'b0;
            chk("t6_cnt", 64'(err_cnt), (k < 3) ? 64'(k) : 64'd3);
            tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
